// File: rtl/enc_pack_scheduler.sv
// enc_pack_scheduler: sequences one sample's level-HV fetch, bind and accumulate across all binder packs
module enc_pack_scheduler #(
   parameter int NUM_PACKS = 53,
   parameter int MEM_LAT   = 2,
   parameter int BIND_LAT  = 1,
   parameter int PW        = $clog2(NUM_PACKS)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   output logic                 sample_ready,
   input  logic                 abort,
   output logic                 busy,
   output logic                 done,
   output logic [PW-1:0]        pack_idx,
   output logic                 mem_rd_en,
   output logic [NUM_PACKS-1:0] start_encoding,
   output logic                 acc_valid,
   input  logic                 acc_ready,
   output logic                 acc_first,
   output logic                 acc_last
);
   localparam int MAXL = (MEM_LAT > BIND_LAT) ? MEM_LAT : BIND_LAT;
   localparam int CW   = $clog2(MAXL + 1);
   localparam logic [PW-1:0] LAST = PW'(NUM_PACKS - 1);

   typedef enum logic [2:0] {IDLE, READ, MWAIT, BIND, BWAIT, EMIT, FINISH} state_t;

   state_t          r_state, w_next;
   logic [PW-1:0]   r_idx, w_idx;
   logic [CW-1:0]   r_cnt, w_cnt;

   // state, pack index and latency counter registers
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_idx   <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_next;
         r_idx   <= w_idx;
         r_cnt   <= w_cnt;
      end
   end

   // next state: the next pack is only fetched after the current one is handed off
   always_comb begin
      w_next = r_state;
      w_idx  = r_idx;
      w_cnt  = r_cnt;
      case (r_state)
         IDLE: begin
            w_next = start ? READ : IDLE;
            w_idx  = '0;
         end
         READ: begin
            w_next = (MEM_LAT == 1) ? BIND : MWAIT;
            w_cnt  = CW'(MEM_LAT - 1);
         end
         MWAIT: begin
            w_next = (r_cnt == CW'(1)) ? BIND : MWAIT;
            w_cnt  = r_cnt - 1'b1;
         end
         BIND: begin
            w_next = (BIND_LAT == 1) ? EMIT : BWAIT;
            w_cnt  = CW'(BIND_LAT - 1);
         end
         BWAIT: begin
            w_next = (r_cnt == CW'(1)) ? EMIT : BWAIT;
            w_cnt  = r_cnt - 1'b1;
         end
         EMIT: begin
            w_next = !acc_ready ? EMIT : (r_idx == LAST) ? FINISH : READ;
            w_idx  = (acc_ready && r_idx != LAST) ? r_idx + 1'b1 : r_idx;
         end
         FINISH: begin
            w_next = start ? READ : IDLE;
            w_idx  = '0;
         end
         default: w_next = IDLE;
      endcase
      if (abort && r_state != IDLE) begin
         w_next = IDLE;
         w_idx  = '0;
         w_cnt  = '0;
      end
   end

   // outputs decoded from the current state only
   always_comb begin
      sample_ready   = (r_state == IDLE) || (r_state == FINISH);
      busy           = !sample_ready;
      done           = (r_state == FINISH);
      mem_rd_en      = (r_state == READ);
      start_encoding = (r_state == BIND) ? (NUM_PACKS'(1) << r_idx) : '0;
      acc_valid      = (r_state == EMIT);
      acc_first      = (r_state == EMIT) && (r_idx == '0);
      acc_last       = (r_state == EMIT) && (r_idx == LAST);
   end

   assign pack_idx = r_idx;

endmodule

// File: tb/tb_enc_pack_scheduler.sv
// tb_enc_pack_scheduler: directed checks of pack sequencing, backpressure, abort and reset
module tb_enc_pack_scheduler;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0, abort = 1'b0, acc_ready = 1'b1;
   logic        sample_ready, busy, done, mem_rd_en, acc_valid, acc_first, acc_last;
   logic [5:0]  pack_idx;
   logic [52:0] start_encoding;

   logic        s_start = 1'b0, s_abort = 1'b0, s_acc_ready = 1'b1;
   logic        s_ready, s_busy, s_done, s_rd, s_av, s_first, s_last;
   logic [1:0]  s_idx;
   logic [2:0]  s_se;

   int n_chk = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   enc_pack_scheduler u_dut (
      .clk(clk), .rst(rst), .start(start), .sample_ready(sample_ready), .abort(abort),
      .busy(busy), .done(done), .pack_idx(pack_idx), .mem_rd_en(mem_rd_en),
      .start_encoding(start_encoding), .acc_valid(acc_valid), .acc_ready(acc_ready),
      .acc_first(acc_first), .acc_last(acc_last)
   );

   enc_pack_scheduler #(.NUM_PACKS(3), .MEM_LAT(1), .BIND_LAT(1)) u_small (
      .clk(clk), .rst(rst), .start(s_start), .sample_ready(s_ready), .abort(s_abort),
      .busy(s_busy), .done(s_done), .pack_idx(s_idx), .mem_rd_en(s_rd),
      .start_encoding(s_se), .acc_valid(s_av), .acc_ready(s_acc_ready),
      .acc_first(s_first), .acc_last(s_last)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   initial begin
      int k, ph, n_rd, n_done, cnt;
      tick;
      tick;
      chk("rst_flags", {sample_ready, busy, done, mem_rd_en, acc_valid, acc_first, acc_last}, 7'b1000000);
      chk("rst_idx_se", {pack_idx, start_encoding}, 0);
      rst = 1'b0;
      tick;
      chk("idle_stay", {sample_ready, busy, mem_rd_en}, 3'b100);

      // full sample: pack k reads at t=4k, binds at 4k+2, emits at 4k+3; done at t=212,
      // i.e. 214 cycles counting both the accept cycle (t=-1) and the done cycle
      start = 1'b1;
      tick;
      start = 1'b0;
      for (int t = 0; t <= 212; t++) begin
         k = t / 4;
         ph = t % 4;
         if (t < 212) begin
            chk($sformatf("run1_t%0d", t), {pack_idx, mem_rd_en, acc_valid, acc_first, acc_last, done},
                {6'(k), ph == 0, ph == 3, ph == 3 && k == 0, ph == 3 && k == 52, 1'b0});
            chk($sformatf("run1_se_t%0d", t), start_encoding, (ph == 2) ? (53'd1 << k) : 53'd0);
         end else
            chk("run1_done", {done, busy, sample_ready, acc_valid}, 4'b1010);
         tick;
      end
      chk("run1_idle", {sample_ready, busy, done, mem_rd_en}, 4'b1000);

      // backpressure at pack 7
      start = 1'b1;
      tick;
      start = 1'b0;
      for (int i = 0; i < 100 && !(acc_valid && pack_idx == 6'd7); i++) tick;
      chk("bp_reach", {acc_valid, pack_idx}, {1'b1, 6'd7});
      acc_ready = 1'b0;
      repeat (5) begin
         tick;
         chk("bp_hold", {acc_valid, pack_idx, mem_rd_en}, {1'b1, 6'd7, 1'b0});
      end
      acc_ready = 1'b1;
      tick;
      chk("bp_rd8", {mem_rd_en, pack_idx, acc_valid}, {1'b1, 6'd8, 1'b0});

      // abort while waiting on memory for pack 20
      for (int i = 0; i < 100 && !(mem_rd_en && pack_idx == 6'd20); i++) tick;
      chk("ab_reach", {mem_rd_en, pack_idx}, {1'b1, 6'd20});
      tick;
      chk("ab_wait", {busy, mem_rd_en, acc_valid}, 3'b100);
      abort = 1'b1;
      tick;
      abort = 1'b0;
      chk("ab_idle", {sample_ready, busy, done, mem_rd_en, acc_valid, pack_idx}, {5'b10000, 6'd0});
      repeat (3) begin
         tick;
         chk("ab_nodone", {done, busy}, 2'b00);
      end
      start = 1'b1;
      tick;
      start = 1'b0;
      chk("ab_restart", {mem_rd_en, pack_idx}, {1'b1, 6'd0});

      // abort in EMIT with acc_ready high: no handshake, no next read
      repeat (3) tick;
      chk("ab2_emit", {acc_valid, acc_first, pack_idx}, {2'b11, 6'd0});
      abort = 1'b1;
      acc_ready = 1'b1;
      tick;
      abort = 1'b0;
      chk("ab2_idle", {sample_ready, busy, mem_rd_en, acc_valid, done, pack_idx}, {5'b10000, 6'd0});
      tick;
      chk("ab2_stay", {busy, mem_rd_en}, 2'b00);

      // reset mid-EMIT
      start = 1'b1;
      tick;
      start = 1'b0;
      for (int i = 0; i < 50 && !(acc_valid && pack_idx == 6'd2); i++) tick;
      chk("rst_reach", {acc_valid, pack_idx}, {1'b1, 6'd2});
      rst = 1'b1;
      tick;
      chk("rst_outs", {sample_ready, busy, done, mem_rd_en, acc_valid, acc_first, acc_last, pack_idx}, {7'b1000000, 6'd0});
      chk("rst_se", start_encoding, 0);
      rst = 1'b0;
      tick;
      chk("rst_nodone", {done, busy}, 2'b00);

      // start held high: back-to-back samples, no extra sample from start while busy
      start = 1'b1;
      tick;
      n_rd = 0;
      n_done = 0;
      for (int t = 0; t <= 425; t++) begin
         if (mem_rd_en) n_rd++;
         if (done) n_done++;
         if (t == 212) chk("b2b_done1", done, 1);
         if (t == 213) chk("b2b_read", {mem_rd_en, pack_idx, busy}, {1'b1, 6'd0, 1'b1});
         if (t == 425) begin
            chk("b2b_done2", done, 1);
            start = 1'b0;
         end
         tick;
      end
      chk("b2b_rd_cnt", n_rd, 106);
      chk("b2b_done_cnt", n_done, 2);
      chk("b2b_idle", {sample_ready, busy, mem_rd_en}, 3'b100);

      // small config: 3-cycle pack spacing, done at t=9 (11 cycles inclusive of accept)
      s_start = 1'b1;
      tick;
      s_start = 1'b0;
      for (int t = 0; t <= 9; t++) begin
         k = t / 3;
         ph = t % 3;
         if (t < 9) begin
            chk($sformatf("s_t%0d", t), {s_idx, s_rd, s_av, s_first, s_last, s_done},
                {2'(k), ph == 0, ph == 2, ph == 2 && k == 0, ph == 2 && k == 2, 1'b0});
            chk($sformatf("s_se_t%0d", t), s_se, (ph == 1) ? (3'b001 << k) : 3'b000);
         end else begin
            chk("s_done", {s_done, s_busy}, 2'b10);
            s_start = 1'b1;
            s_abort = 1'b1;
         end
         tick;
      end
      s_start = 1'b0;
      s_abort = 1'b0;
      chk("s_abort_fin", {s_ready, s_busy, s_rd}, 3'b100);

      s_start = 1'b1;
      tick;
      s_start = 1'b0;
      cnt = 0;
      for (int i = 0; i < 20 && !s_done; i++) begin
         tick;
         cnt++;
      end
      chk("s_lat2", {s_done, 8'(cnt)}, {1'b1, 8'd9});
      s_start = 1'b1;
      tick;
      s_start = 1'b0;
      chk("s_fin_accept", {s_rd, s_idx, s_busy}, {1'b1, 2'd0, 1'b1});

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end
endmodule
